// File: rtl/neo_dtack_pkg.sv
// neo_dtack shared types: FSM states, zone nibbles, wait constants.
// Build option NEO_DTACK_TIMEOUT_EN enables the bus-error timeout.
package neo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [3:0] ZONE_ROM     = 4'h0;
    localparam logic [3:0] ZONE_WRAM    = 4'h1;
    localparam logic [3:0] ZONE_PORT    = 4'h2;
    localparam logic [3:0] ZONE_IO      = 4'h3;
    localparam logic [3:0] ZONE_PAL     = 4'h4;
    localparam logic [3:0] ZONE_MEMCARD = 4'h8;
    localparam logic [3:0] ZONE_BIOS    = 4'hC;
    localparam logic [3:0] ZONE_SRAM    = 4'hD;

    localparam logic [1:0] ZERO_WAITS     = 2'd0;
    localparam logic [1:0] ROM_SLOW_WAITS = 2'd1;
    localparam logic [1:0] MEMCARD_WAITS  = 2'd2;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int TMO_W          = 6;

    // Byte address bits A23..A20 live in word address bits [22:19].
    function automatic logic [3:0] zone_of(input logic [22:0] addr);
        return addr[22:19];
    endfunction

endpackage

// File: rtl/neo_dtack_if.sv
// neo_dtack 68k-side bus bundle: CPU/cart request side and acknowledge side.
// nBERR is only driven low when NEO_DTACK_TIMEOUT_EN is defined.
interface neo_dtack_if;

    logic [22:0] M68K_ADDR;
    logic        nAS;
    logic        ROMWAIT;
    logic [1:0]  PWAIT;
    logic        PDTACK;
    logic        nPDTACK;
    logic        nDTACK;
    logic        nBERR;
    logic        BUSY;

    modport master (
        output M68K_ADDR,
        output nAS,
        output ROMWAIT,
        output PWAIT,
        output PDTACK,
        output nPDTACK,
        input  nDTACK,
        input  nBERR,
        input  BUSY
    );

    modport slave (
        input  M68K_ADDR,
        input  nAS,
        input  ROMWAIT,
        input  PWAIT,
        input  PDTACK,
        input  nPDTACK,
        output nDTACK,
        output nBERR,
        output BUSY
    );

endinterface

// File: rtl/neo_zone_dec.sv
// neo_zone_dec: address zone to wait-count / external-ack / unmapped.
// Purely combinational; used by neo_dtack (NEO_DTACK_TIMEOUT_EN agnostic).
module neo_zone_dec
    import neo_pkg::*;
(
    input  logic [3:0] zone_i,
    input  logic       romwait_i,
    input  logic [1:0] pwait_i,
    input  logic       pdtack_i,
    output logic [1:0] waits_o,
    output logic       ext_o,
    output logic       unmapped_o
);

    // Map each zone nibble to its wait count and acknowledge source.
    always_comb begin
        waits_o    = ZERO_WAITS;
        ext_o      = 1'b0;
        unmapped_o = 1'b0;
        unique case (zone_i)
            ZONE_ROM: begin
                waits_o = romwait_i ? ZERO_WAITS : ROM_SLOW_WAITS;
            end
            ZONE_WRAM,
            ZONE_IO,
            ZONE_PAL,
            ZONE_BIOS,
            ZONE_SRAM: begin
                waits_o = ZERO_WAITS;
            end
            ZONE_PORT: begin
                waits_o = pwait_i;
                ext_o   = pdtack_i;
            end
            ZONE_MEMCARD: begin
                waits_o = MEMCARD_WAITS;
            end
            default: begin
                unmapped_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/neo_dtack.sv
// neo_dtack: 68k DTACK generator with per-zone wait states.
// Define NEO_DTACK_TIMEOUT_EN for the 64-edge bus-error timeout.
module neo_dtack
    import neo_pkg::*;
(
    input  logic  CLK_68KCLK,
    input  logic  nRESET,
    neo_dtack_if.slave bus
);

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        ext_q;
    logic        pd_q;
    logic        dtack_n_q;
    logic        busy_q;

    logic [1:0]  dec_waits;
    logic        dec_ext;
    logic        dec_unm;
    logic        ack_now;

    neo_zone_dec u_dec (
        .zone_i     (zone_of(bus.M68K_ADDR)),
        .romwait_i  (bus.ROMWAIT),
        .pwait_i    (bus.PWAIT),
        .pdtack_i   (bus.PDTACK),
        .waits_o    (dec_waits),
        .ext_o      (dec_ext),
        .unmapped_o (dec_unm)
    );

`ifdef NEO_DTACK_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             unm_q;
    logic             berr_n_q;
    logic [TMO_W-1:0] tmo_q;
    logic             unused_bits;

    // Unmapped zones never count down; only the timeout ends them.
    assign ack_now = ext_q ? pd_q : (!unm_q && cnt_q == 2'd0);
    assign bus.nBERR = berr_n_q;
    assign unused_bits = ^bus.M68K_ADDR[18:0];
`else
    logic unused_bits;

    // Unmapped zones fall through as zero-wait accesses.
    assign ack_now = ext_q ? pd_q : (cnt_q == 2'd0);
    assign bus.nBERR = 1'b1;
    assign unused_bits = ^{bus.M68K_ADDR[18:0], dec_unm};
`endif

    assign bus.nDTACK = dtack_n_q;
    assign bus.BUSY   = busy_q;

    // Cycle FSM: latch zone at E1, count waits, hold ack until nAS rises.
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            ext_q     <= 1'b0;
            pd_q      <= 1'b0;
            dtack_n_q <= 1'b1;
            busy_q    <= 1'b0;
`ifdef NEO_DTACK_TIMEOUT_EN
            unm_q     <= 1'b0;
            berr_n_q  <= 1'b1;
            tmo_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.nAS) begin
                        state_q <= WAIT;
                        cnt_q   <= dec_waits;
                        ext_q   <= dec_ext;
                        pd_q    <= dec_ext & ~bus.nPDTACK;
                        busy_q  <= 1'b1;
`ifdef NEO_DTACK_TIMEOUT_EN
                        unm_q   <= dec_unm;
                        tmo_q   <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (bus.nAS) begin
                        state_q <= IDLE;
                        cnt_q   <= 2'd0;
                        ext_q   <= 1'b0;
                        pd_q    <= 1'b0;
                        busy_q  <= 1'b0;
`ifdef NEO_DTACK_TIMEOUT_EN
                        unm_q   <= 1'b0;
                        tmo_q   <= '0;
`endif
                    end else if (ack_now) begin
                        state_q   <= ACK;
                        dtack_n_q <= 1'b0;
`ifdef NEO_DTACK_TIMEOUT_EN
                    end else if (tmo_q == TMO_LAST) begin
                        state_q  <= HOLD;
                        berr_n_q <= 1'b0;
`endif
                    end else begin
                        if (cnt_q != 2'd0) begin
                            cnt_q <= cnt_q - 2'd1;
                        end
                        pd_q <= ext_q & ~bus.nPDTACK;
`ifdef NEO_DTACK_TIMEOUT_EN
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                ACK,
                HOLD: begin
                    if (bus.nAS) begin
                        state_q   <= IDLE;
                        cnt_q     <= 2'd0;
                        ext_q     <= 1'b0;
                        pd_q      <= 1'b0;
                        dtack_n_q <= 1'b1;
                        busy_q    <= 1'b0;
`ifdef NEO_DTACK_TIMEOUT_EN
                        unm_q     <= 1'b0;
                        berr_n_q  <= 1'b1;
                        tmo_q     <= '0;
`endif
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
